// File: rtl/ram8_bank.sv
// ram8_bank: eight-word Hack RAM8 register bank.
// A three-level demux tree steers the load strobe to exactly one word's write enable.
// The read path is a combinational 8-way mux that selects word[address].
module ram8_bank #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out
);

  localparam int unsigned Depth = 1 << ADDR_W;

  // The decode tree below is hard-wired for exactly three address bits.
  if (ADDR_W != 3) begin : gen_bad_addr_w
    $error("ram8_bank: ADDR_W must be 3");
  end

  // Hack DMux: the selected output carries d_in, the other output is 0.
  // The result is {b, a}, where a is routed when sel = 0 and b when sel = 1.
  function automatic logic [1:0] demux(input logic d_in, input logic sel);
    demux = sel ? {d_in, 1'b0} : {1'b0, d_in};
  endfunction

  logic [1:0]       en_l1;
  logic [3:0]       en_l2;
  logic [Depth-1:0] en_l3;

  logic [WIDTH-1:0] word_q [Depth];
  logic [WIDTH-1:0] word_d [Depth];

  // Load decode: split on address[2], then address[1], then address[0].
  always_comb begin
    en_l1 = demux(load, address[2]);
    en_l2 = {demux(en_l1[1], address[1]), demux(en_l1[0], address[1])};
    en_l3 = {demux(en_l2[3], address[0]), demux(en_l2[2], address[0]),
             demux(en_l2[1], address[0]), demux(en_l2[0], address[0])};
  end

  // Next state: only the enabled word takes the write data; all others hold.
  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      word_d[i] = word_q[i];
      if (en_l3[i]) begin
        word_d[i] = in;
      end
    end
  end

  // Word storage; asserting reset clears every word at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        word_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        word_q[i] <= word_d[i];
      end
    end
  end

  // Read mux: combinational, with no write-through bypass.
  always_comb begin
    out = word_q[address];
  end

endmodule

// File: tb/tb_ram8_bank.sv
// tb_ram8_bank: directed test of ram8_bank against a small shadow memory.
module tb_ram8_bank;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] mem_m [8];

  ram8_bank #(
    .WIDTH  (16),
    .ADDR_W (3)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so that the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, required finish before 100000");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive inputs at the falling edge, write on the rising edge, then release load.
  task automatic write_word(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a;
    in      = d;
    load    = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
    address = a;
    #1;
    check_eq(tag, out, exp);
  endtask

  initial begin
    rst_n   = 1'b0;
    in      = '0;
    load    = 1'b0;
    address = '0;
    for (int i = 0; i < 8; i++) mem_m[i] = '0;

    // The output must read 0 while reset is held, regardless of address.
    #2;
    check_eq("reset_out_a0", out, 16'h0000);
    address = 3'd6;
    #1;
    check_eq("reset_out_a6", out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset clear: fill all words, then pulse reset between clock edges.
    for (int k = 0; k < 8; k++) write_word(k[2:0], 16'hFFFF);
    read_check("prefill_a4", 3'd4, 16'hFFFF);
    rst_n = 1'b0;
    #1;
    check_eq("reset_pulse_live", out, 16'h0000);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mem_m[i] = '0;
    for (int k = 0; k < 8; k++) read_check("reset_clear", k[2:0], 16'h0000);

    // Write isolation: each word gets a distinct value, with no aliasing.
    for (int k = 0; k < 8; k++) write_word(k[2:0], 16'h1000 + 16'(k));
    for (int k = 0; k < 8; k++) read_check("isolation", k[2:0], 16'h1000 + 16'(k));

    // With load low, word 5 holds its value for three edges.
    @(negedge clk);
    address = 3'd5;
    in      = 16'hDEAD;
    load    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("load_low_hold", out, 16'h1005);

    // Write timing: the old value is visible before the edge, the new value after it.
    @(negedge clk);
    address = 3'd2;
    in      = 16'hBEEF;
    load    = 1'b1;
    #4;
    check_eq("pre_edge_old", out, 16'h1002);
    @(posedge clk);
    #1;
    check_eq("post_edge_new", out, 16'hBEEF);
    load = 1'b0;
    mem_m[2] = 16'hBEEF;
    read_check("neighbour_a3", 3'd3, 16'h1003);

    // Combinational sweep: step through all addresses in 1ns steps within one period.
    @(negedge clk);
    for (int k = 0; k < 8; k++) read_check("comb_sweep", k[2:0], mem_m[k]);

    // Reset coincident with a write edge: reset must win.
    @(negedge clk);
    address = 3'd7;
    in      = 16'h1234;
    load    = 1'b1;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    load = 1'b0;
    check_eq("rst_vs_write_held", out, 16'h0000);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mem_m[i] = '0;
    #1;
    check_eq("rst_vs_write_a7", out, 16'h0000);
    read_check("rst_cleared_a2", 3'd2, 16'h0000);
    write_word(3'd7, 16'h1234);
    read_check("rewrite_a7", 3'd7, 16'h1234);
    read_check("rewrite_a6_zero", 3'd6, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
